// File: rtl/rs232_tx_param.sv
// rs232_tx_param: parameterised RS-232 serializer, optional parity and
// one or two stop bits, words taken on a valid/ready handshake.
module rs232_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              op_bit,
    output logic              idle,
    output logic              start,
    output logic              stop,
    output logic              tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_W - 1);
    localparam logic STOP_MAX = 1'(STOP_BITS - 1);
    localparam bit   HAS_PAR  = (PARITY != 0);
    localparam bit   ODD_PAR  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_sidx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;

    logic r_op;
    logic r_idle;
    logic r_start;
    logic r_stop;
    logic r_done;

    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic              w_sidx_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_par_nxt;

    logic w_accept;
    logic w_bit_end;

    logic w_op_nxt;
    logic w_idle_nxt;
    logic w_start_nxt;
    logic w_stop_nxt;
    logic w_done_nxt;

    assign data_ready = (r_state == S_IDLE);
    assign w_accept   = data_valid && data_ready;
    assign w_bit_end  = (r_cnt == CNT_MAX);

    assign op_bit  = r_op;
    assign idle    = r_idle;
    assign start   = r_start;
    assign stop    = r_stop;
    assign tx_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sidx  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sidx  <= w_sidx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sidx_nxt  = r_sidx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = data;
                    w_par_nxt   = (^data) ^ ODD_PAR;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == IDX_MAX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_sidx == STOP_MAX) begin
                        w_sidx_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_sidx_nxt = r_sidx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Bit timer restarts on each bit boundary and on each state change.
        if (w_state_nxt != r_state || w_bit_end || r_state == S_IDLE)
            w_cnt_nxt = '0;
        else
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Outputs are decoded from next-state values and registered.
    always_comb begin
        w_op_nxt    = 1'b1;
        w_idle_nxt  = 1'b0;
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        unique case (w_state_nxt)
            S_IDLE:  w_idle_nxt = 1'b1;
            S_START: begin
                w_op_nxt    = 1'b0;
                w_start_nxt = 1'b1;
            end
            S_DATA:  w_op_nxt = w_shift_nxt[0];
            S_PAR:   w_op_nxt = w_par_nxt;
            S_STOP: begin
                w_stop_nxt = 1'b1;
                w_done_nxt = (w_cnt_nxt == CNT_MAX) &&
                             (w_sidx_nxt == STOP_MAX);
            end
            default: w_op_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 1'b1;
            r_idle  <= 1'b1;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_op    <= w_op_nxt;
            r_idle  <= w_idle_nxt;
            r_start <= w_start_nxt;
            r_stop  <= w_stop_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_rs232_tx_param.sv
// tb_rs232_tx_param: five parameter sets run side by side, each checked
// every cycle against a frame-position model plus literal frame samples.
module tb_rs232_tx_param;

    localparam int NCFG = 5;
    localparam int CFG_DW    [NCFG] = '{8, 8, 8, 8, 5};
    localparam int CFG_CPB   [NCFG] = '{4, 4, 4, 4, 3};
    localparam int CFG_PAR   [NCFG] = '{2, 1, 0, 0, 1};
    localparam int CFG_STP   [NCFG] = '{1, 1, 1, 2, 1};
    localparam int CFG_W1    [NCFG] = '{'hAA, 'hAA, 'hAA, 'h55, 'h13};
    localparam int CFG_SEQ   [NCFG] = '{'h554, 'h754, 'h354, 'h6AA, 'hA6};
    localparam int CFG_NBIT  [NCFG] = '{11, 11, 10, 11, 8};
    localparam int CFG_LEN   [NCFG] = '{44, 44, 40, 44, 24};
    localparam int CFG_STOPC [NCFG] = '{4, 4, 4, 8, 3};

    logic clk = 1'b0;
    logic rst_n;
    int   checks;
    int   failures;
    int   phase;
    int   done_cnt;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s cfg%0d got=%0h want=%0h", nm, g, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gc
        localparam int DW = CFG_DW[g];
        localparam int C  = CFG_CPB[g];
        localparam int P  = CFG_PAR[g];
        localparam int S  = CFG_STP[g];
        localparam int HP = (P != 0) ? 1 : 0;
        localparam int FL = (1 + DW + HP + S) * C;
        localparam int SB = (1 + DW + HP) * C;

        logic [DW-1:0] d;
        logic v, rdy, op, idl, st, sp, dn;

        rs232_tx_param #(
            .DATA_W(DW),
            .CLKS_PER_BIT(C),
            .PARITY(P),
            .STOP_BITS(S)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .data(d),
            .data_valid(v),
            .data_ready(rdy),
            .op_bit(op),
            .idle(idl),
            .start(st),
            .stop(sp),
            .tx_done(dn)
        );

        // Model: position p within the current frame, or not busy.
        bit            busy;
        int            p;
        logic [DW-1:0] w;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy <= 1'b0;
                p    <= 0;
            end else if (busy) begin
                p <= p + 1;
                if (p == FL - 1) busy <= 1'b0;
            end else if (v) begin
                busy <= 1'b1;
                p    <= 0;
                w    <= d;
            end
        end

        function automatic logic fbit(input int k, input logic [DW-1:0] x);
            logic [DW-1:0] t;
            if (k == 0) return 1'b0;
            t = x >> (k - 1);
            if (k <= DW) return t[0];
            if (HP == 1 && k == DW + 1) return (P == 2) ? ^x : ~^x;
            return 1'b1;
        endfunction

        always @(negedge clk) begin
            logic [5:0] e;
            int k;
            k = p / C;
            if (busy)
                e = {1'b0, fbit(k, w), 1'b0, (k == 0),
                     (k >= 1 + DW + HP), (p == FL - 1)};
            else
                e = 6'b111000;
            chk("outputs", g, {26'd0, rdy, op, idl, st, sp, dn}, int'(e));
        end

        always @(negedge rst_n) begin
            #1;
            chk("rst_async", g, {26'd0, rdy, op, idl, st, sp, dn}, 'h38);
        end

        initial begin
            int seq, nb, len, ndone, stage, stopc, gap;
            d = '0;
            v = 1'b0;
            wait (phase == 1);
            @(negedge clk);
            d = DW'(CFG_W1[g]);
            v = 1'b1;
            @(negedge clk);
            v = 1'b0;
            d = '0;
            seq = 0; nb = 0; len = -1; ndone = 0;
            for (int n = 0; n < 400 && len < 0; n++) begin
                if (n % C == C / 2 && nb < 16) begin
                    seq = seq | (int'(op) << nb);
                    nb++;
                end
                if (dn === 1'b1) ndone++;
                if (idl === 1'b1) len = n;
                if (n == SB + 1) v = 1'b1;
                if (n == SB + 2) v = 1'b0;
                if (len < 0) @(negedge clk);
            end
            chk("bit_samples", g, seq, CFG_SEQ[g]);
            chk("bit_count", g, nb, CFG_NBIT[g]);
            chk("frame_len", g, len, CFG_LEN[g]);
            chk("done_pulses", g, ndone, 1);

            @(negedge clk);
            d = DW'('h55);
            v = 1'b1;
            @(negedge clk);
            d = DW'('h0F);
            stage = 0; stopc = 0; gap = 0;
            for (int n = 0; n < 400 && stage < 3; n++) begin
                if (stage == 0) begin
                    if (sp === 1'b1) stopc++;
                    if (idl === 1'b1) begin
                        stage = 1;
                        gap = 1;
                    end
                end else if (stage == 1) begin
                    if (idl === 1'b1) gap++;
                    else begin
                        stage = 2;
                        v = 1'b0;
                    end
                end else if (idl === 1'b1) begin
                    stage = 3;
                end
                if (stage < 3) @(negedge clk);
            end
            v = 1'b0;
            chk("stop_cycles", g, stopc, CFG_STOPC[g]);
            chk("idle_gap", g, gap, 1);
            chk("b2b_end", g, stage, 3);
            done_cnt++;

            wait (phase == 2);
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                v = ($urandom_range(0, 3) == 0);
                d = DW'($urandom);
            end
            @(negedge clk);
            v = 1'b0;
            for (int n = 0; n < 200 && idl !== 1'b1; n++) @(negedge clk);
            chk("drain", g, {31'd0, idl}, 1);
            done_cnt++;

            wait (phase == 3);
            @(negedge clk);
            d = DW'('hAA);
            v = 1'b1;
            @(negedge clk);
            v = 1'b0;
            done_cnt++;

            wait (phase == 4);
            d = DW'('hAA);
            v = 1'b1;
            @(negedge clk);
            v = 1'b0;
            for (int n = 0; n < 200 && idl !== 1'b1; n++) @(negedge clk);
            chk("post_rst_end", g, {31'd0, idl}, 1);
            done_cnt++;
        end
    end

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("phase_done", 0, done_cnt, target);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        phase    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        phase = 1;
        wait_done(NCFG);
        phase = 2;
        wait_done(2 * NCFG);
        phase = 3;
        wait_done(3 * NCFG);
        repeat (16) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        phase = 4;
        wait_done(4 * NCFG);
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs232_tx_param.md
RS232_TX_PARAM -- requirements
Module: rs232_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal >= 2).
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-005 The block SHALL use one clock and one reset: clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data  input  DATA_W  parallel word to send.
REQ-008 data_valid  input  1  data holds a word to send.
REQ-009 data_ready  output  1  block accepts a word this cycle.
REQ-010 op_bit  output  1  serial line, idle-high.
REQ-011 idle  output  1  high in IDLE state.
REQ-012 start  output  1  high while the start bit is driven.
REQ-013 stop  output  1  high while any stop bit is driven.
REQ-014 tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-016 data_ready SHALL equal 1 only in IDLE; a word is accepted at a rising edge with data_valid=1 and data_ready=1.
REQ-017 On accept, data SHALL be latched into a shift register and the FSM SHALL enter START; later changes to data SHALL be ignored until the next accept.
REQ-018 START SHALL drive op_bit=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA SHALL drive the latched bits LSB first, each for exactly CLKS_PER_BIT cycles; after bit DATA_W-1 it SHALL enter PAR if PARITY!=0, else STOP.
REQ-020 PAR SHALL drive, for CLKS_PER_BIT cycles, XOR of latched bits (even) or its inverse (odd), then enter STOP.
REQ-021 STOP SHALL drive op_bit=1 for STOP_BITS*CLKS_PER_BIT cycles, pulse tx_done in the final cycle, then enter IDLE.
REQ-022 IDLE SHALL drive op_bit=1; at least one IDLE cycle SHALL separate consecutive frames, even with data_valid held high.
REQ-023 Frame length, accept edge to IDLE re-entry, SHALL be (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, wrap to 0 on every bit boundary, and reset to 0 on every state change.
REQ-025 The bit index counter SHALL count 0..DATA_W-1 in DATA only and clear on leaving DATA.
REQ-026 idle, start and stop SHALL be registered and mutually exclusive; all three SHALL be 0 in DATA and PAR.
REQ-027 data_valid asserted outside IDLE SHALL have no effect; it is not queued.
REQ-028 All outputs except data_ready SHALL be registered; op_bit SHALL be glitch-free.

Reset
REQ-029 While rst_n=0, state SHALL be IDLE, op_bit=1, idle=1, start=0, stop=0, tx_done=0, data_ready=1, and all counters 0.
REQ-030 rst_n assertion mid-frame SHALL abort immediately (asynchronously) with op_bit=1 and no tx_done pulse; the aborted word SHALL be discarded.
REQ-031 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-032 DATA_W=8, CLKS_PER_BIT=4, PARITY=2, STOP_BITS=1, data=0xAA pulsed valid -> op_bit sampled per bit: 0,0,1,0,1,0,1,0,1,0,1; 44 cycles; tx_done once.
REQ-033 Same with PARITY=1 -> parity bit 1; PARITY=0 -> no parity bit, frame 40 cycles.
REQ-034 STOP_BITS=2, data_valid held high, words 0x55 then 0x0F -> stop high 8 cycles, exactly one IDLE cycle between frames, both words bit-exact.
REQ-035 DATA_W=5, data=5'b10011 -> bits 1,1,0,0,1 LSB first; data changed mid-frame to 0 -> transmission unchanged.
REQ-036 rst_n pulsed low during DATA bit 3 -> op_bit=1 and idle=1 without waiting for clk, no tx_done; next frame 0xAA correct.
REQ-037 data_valid pulsed during STOP -> ignored; data_ready=0 throughout the frame and 1 in IDLE.
